ibex_fetch_req_ctrl: RTL and testbench
======================================

IBEX_FETCH_REQ_CTRL -- requirements
Module: ibex_fetch_req_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQS, default 2, giving the maximum number of outstanding bus requests and the number of upper fetch FIFO entries reported busy.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 req_i  in  1  core permits fetching.
REQ-005 branch_i  in  1  redirect fetch to branch_addr_i this cycle.
REQ-006 branch_addr_i  in  32  branch target; halfword aligned, bit 0 ignored.
REQ-007 busy_o  out  1  a bus request is pending or a response is outstanding.
REQ-008 instr_req_o / instr_addr_o[31:0]  out  1/32  bus request and word-aligned address.
REQ-009 instr_gnt_i  in  1  request accepted.
REQ-010 instr_rvalid_i / instr_rdata_i[31:0] / instr_err_i  in  1/32/1  in-order response.
REQ-011 fifo_clear_o / fifo_addr_o[31:0]  out  1/32  fetch FIFO clear and restart address.
REQ-012 fifo_valid_o / fifo_rdata_o[31:0] / fifo_err_o  out  1/32/1  fetch FIFO push.
REQ-013 fifo_busy_i  in  NUM_REQS  occupancy of the upper fetch FIFO entries.

Function
REQ-014 State: fetch_addr_q[31:2], outstanding_q (0..NUM_REQS), discard_q (0..NUM_REQS), FSM {IDLE, WAIT_GNT}, stored_addr_q[31:2], branch_pend_q.
REQ-015 space_ok = outstanding_q + popcount(fifo_busy_i) < NUM_REQS; on a branch_i cycle fifo_busy_i is ignored, so space_ok = outstanding_q < NUM_REQS.
REQ-016 IDLE: instr_req_o = req_i & space_ok; instr_addr_o = branch_i ? {branch_addr_i[31:2],2'b00} : {fetch_addr_q,2'b00}.
REQ-017 IDLE, instr_req_o=1 & instr_gnt_i=0 -> WAIT_GNT and stored_addr_q = presented address.
REQ-018 WAIT_GNT: instr_req_o = 1 and instr_addr_o = stored_addr_q regardless of req_i, branch_i or space; return to IDLE on instr_gnt_i.
REQ-019 On every grant, fetch_addr_q = granted address + 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-020 branch_i in IDLE: fetch_addr_q = branch_addr_i[31:2], +4 if granted the same cycle.
REQ-021 branch_i in WAIT_GNT: set branch_pend_q and latch the target into fetch_addr_q; the held request, when granted, is stale and counts toward discard_q; branch_pend_q clears on that grant.
REQ-022 outstanding_q += grant, -= instr_rvalid_i, both in one cycle allowed; never exceeds NUM_REQS.
REQ-023 fifo_clear_o = branch_i; fifo_addr_o = branch_i ? {branch_addr_i[31:1],1'b0} : 32'h0.
REQ-024 fifo_valid_o = instr_rvalid_i & (discard_q == 0) & ~branch_i; fifo_rdata_o/fifo_err_o pass instr_rdata_i/instr_err_i combinationally (zero latency).
REQ-025 Response with discard_q > 0 SHALL be dropped and decrement discard_q.
REQ-026 On branch_i, discard_q_next = outstanding_q - instr_rvalid_i + (stale grant this cycle); a same-cycle response is dropped.
REQ-027 busy_o = instr_req_o | (outstanding_q != 0).
REQ-028 An instr_rvalid_i with outstanding_q == 0 is a protocol violation; the block SHALL assert on it.

Reset
REQ-029 rst_i high at a clock edge: FSM=IDLE, fetch_addr_q=0, stored_addr_q=0, outstanding_q=0, discard_q=0, branch_pend_q=0.
REQ-030 During reset instr_req_o, fifo_valid_o, fifo_clear_o, busy_o SHALL be 0 and instr_addr_o, fifo_addr_o 32'h0; responses to pre-reset requests are not tracked.

Verification
REQ-031 Reset, branch_i to 0x100, req_i=1, gnt every cycle, rvalid 1 cycle later -> addresses 0x100,0x104,0x108; pushes in order, fifo_clear_o one cycle with fifo_addr_o=0x100.
REQ-032 Branch to 0x202 -> instr_addr_o 0x200, fifo_addr_o 0x202.
REQ-033 Two outstanding, branch to 0x400 -> both responses dropped, first push is rdata for 0x400.
REQ-034 gnt low 3 cycles, branch to 0x800 in cycle 2 -> instr_addr_o held at old address until gnt; next request 0x800; stale response dropped.
REQ-035 fifo_busy_i=2'b11 -> no instr_req_o; fifo_busy_i=2'b01 with one outstanding -> no request.
REQ-036 Branch to 0xFFFFFFFC, two grants -> addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller: issues word-aligned bus requests, tracks
// outstanding responses, discards responses made stale by a branch, feeds the fetch FIFO.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_gnt_i,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    output logic [31:0]         fifo_addr_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [29:0]      r_fetch_addr;
    logic [29:0]      w_fetch_addr_next;
    logic [29:0]      r_stored_addr;
    logic [29:0]      w_stored_addr_next;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] w_outstanding_next;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] w_discard_next;
    logic             r_branch_pend;
    logic             w_branch_pend_next;

    logic             w_req;
    logic [29:0]      w_req_addr;
    logic [29:0]      w_branch_word;
    logic             w_grant;
    logic             w_stale_grant;
    logic             w_drop;
    logic             w_space_ok;
    logic [CNT_W-1:0] w_busy_cnt;
    logic [CNT_W:0]   w_occupancy;
    logic             w_unused_bit0;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REQS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign w_unused_bit0 = branch_addr_i[0];
    assign w_branch_word = branch_addr_i[31:2];

    // A branch flushes the fetch FIFO, so its busy entries no longer limit issue.
    always_comb begin
        w_busy_cnt  = branch_i ? '0 : popcount(fifo_busy_i);
        w_occupancy = {1'b0, r_outstanding} + {1'b0, w_busy_cnt};
        w_space_ok  = w_occupancy < (CNT_W + 1)'(NUM_REQS);
    end

    always_comb begin
        w_state_next       = r_state;
        w_fetch_addr_next  = r_fetch_addr;
        w_stored_addr_next = r_stored_addr;
        w_branch_pend_next = r_branch_pend;
        w_req              = 1'b0;
        w_req_addr         = r_fetch_addr;
        w_stale_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req      = req_i & w_space_ok;
                w_req_addr = branch_i ? w_branch_word : r_fetch_addr;
                if (w_req && instr_gnt_i) begin
                    w_fetch_addr_next = w_req_addr + 30'd1;
                end else begin
                    if (branch_i) begin
                        w_fetch_addr_next = w_branch_word;
                    end
                    if (w_req) begin
                        w_state_next       = WAIT_GNT;
                        w_stored_addr_next = w_req_addr;
                    end
                end
            end
            WAIT_GNT: begin
                // The bus protocol forbids withdrawing a request, so it is held even across a branch.
                w_req      = 1'b1;
                w_req_addr = r_stored_addr;
                if (branch_i) begin
                    w_fetch_addr_next = w_branch_word;
                end
                if (instr_gnt_i) begin
                    w_state_next       = IDLE;
                    w_branch_pend_next = 1'b0;
                    w_stale_grant      = r_branch_pend | branch_i;
                    if (!(r_branch_pend || branch_i)) begin
                        w_fetch_addr_next = r_stored_addr + 30'd1;
                    end
                end else if (branch_i) begin
                    w_branch_pend_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_grant = w_req & instr_gnt_i;
    assign w_drop  = instr_rvalid_i & (r_discard != '0);

    always_comb begin
        w_outstanding_next = r_outstanding + CNT_W'(w_grant) - CNT_W'(instr_rvalid_i);
        // Every response still in flight at a branch belongs to the old instruction stream.
        if (branch_i) begin
            w_discard_next = r_outstanding - CNT_W'(instr_rvalid_i) + CNT_W'(w_stale_grant);
        end else begin
            w_discard_next = r_discard - CNT_W'(w_drop) + CNT_W'(w_stale_grant);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_fetch_addr  <= '0;
            r_stored_addr <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_branch_pend <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_addr  <= w_fetch_addr_next;
            r_stored_addr <= w_stored_addr_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            r_branch_pend <= w_branch_pend_next;
        end
    end

    always_comb begin
        instr_req_o  = w_req & ~rst_i;
        instr_addr_o = rst_i ? 32'h0 : {w_req_addr, 2'b00};
        busy_o       = ~rst_i & (w_req | (r_outstanding != '0));
        fifo_clear_o = branch_i & ~rst_i;
        fifo_addr_o  = (branch_i && !rst_i) ? {branch_addr_i[31:1], 1'b0} : 32'h0;
        fifo_valid_o = ~rst_i & instr_rvalid_i & (r_discard == '0) & ~branch_i;
        fifo_rdata_o = instr_rdata_i;
        fifo_err_o   = instr_err_i;
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(instr_rvalid_i && (r_outstanding == '0)));

    assert property (@(posedge clk_i) disable iff (rst_i)
        r_outstanding <= CNT_W'(NUM_REQS));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: directed scenarios plus random traffic against a
// transaction-level model (queue of in-flight fetches tagged keep/stale).
module tb_ibex_fetch_req_ctrl;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic          branch_i;
    logic [31:0]   branch_addr_i;
    logic          busy_o;
    logic          instr_req_o;
    logic [31:0]   instr_addr_o;
    logic          instr_gnt_i;
    logic          instr_rvalid_i;
    logic [31:0]   instr_rdata_i;
    logic          instr_err_i;
    logic          fifo_clear_o;
    logic [31:0]   fifo_addr_o;
    logic          fifo_valid_o;
    logic [31:0]   fifo_rdata_o;
    logic          fifo_err_o;
    logic [N-1:0]  fifo_busy_i;

    ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .busy_o(busy_o), .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i), .fifo_clear_o(fifo_clear_o), .fifo_addr_o(fifo_addr_o),
        .fifo_valid_o(fifo_valid_o), .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
        .fifo_busy_i(fifo_busy_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: fetches granted but not yet answered, oldest first, with a keep flag.
    logic [31:0] q_addr[$];
    bit          q_keep[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_hold = 1'b0;
    bit          m_hold_stale = 1'b0;
    logic [31:0] m_hold_addr = 32'h0;

    logic        exp_req, exp_clear, exp_valid, exp_busy, drv_err;
    logic [31:0] exp_addr, exp_faddr, exp_rdata;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive(input int rq, input int br, input logic [31:0] ba,
                         input int g, input int rv, input int fb);
        req_i         = (rq != 0);
        branch_i      = (br != 0);
        branch_addr_i = ba;
        instr_gnt_i   = (g != 0);
        fifo_busy_i   = N'(fb);
        drv_err       = ($urandom_range(0, 1) != 0);
        instr_err_i   = drv_err;
        if (rv != 0 && !rst_i && q_addr.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem(q_addr[0]);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
        end
    endtask

    task automatic predict();
        int nb;
        #2;
        exp_req = 1'b0; exp_addr = 32'h0; exp_clear = 1'b0; exp_faddr = 32'h0;
        exp_valid = 1'b0; exp_busy = 1'b0;
        exp_rdata = (q_addr.size() > 0) ? mem(q_addr[0]) : 32'h0;
        if (!rst_i) begin
            exp_clear = branch_i;
            exp_faddr = branch_i ? {branch_addr_i[31:1], 1'b0} : 32'h0;
            if (m_hold) begin
                exp_req  = 1'b1;
                exp_addr = m_hold_addr;
            end else begin
                nb       = branch_i ? 0 : $countones(fifo_busy_i);
                exp_req  = req_i && (q_addr.size() + nb < N);
                exp_addr = branch_i ? {branch_addr_i[31:2], 2'b00} : m_pc;
            end
            exp_valid = instr_rvalid_i && (q_keep.size() > 0) && q_keep[0] && !branch_i;
            exp_busy  = exp_req || (q_addr.size() != 0);
        end
    endtask

    task automatic advance();
        bit stale;
        @(posedge clk);
        if (rst_i) begin
            q_addr.delete(); q_keep.delete();
            m_pc = 32'h0; m_hold = 1'b0; m_hold_stale = 1'b0; m_hold_addr = 32'h0;
        end else begin
            if (instr_rvalid_i) begin
                void'(q_addr.pop_front());
                void'(q_keep.pop_front());
            end
            if (branch_i) begin
                for (int i = 0; i < q_keep.size(); i++) q_keep[i] = 1'b0;
                m_pc = {branch_addr_i[31:2], 2'b00};
            end
            if (exp_req && instr_gnt_i) begin
                stale = m_hold && (m_hold_stale || branch_i);
                q_addr.push_back(exp_addr);
                q_keep.push_back(!stale);
                if (!stale) m_pc = exp_addr + 32'd4;
                m_hold = 1'b0;
            end else if (exp_req && !m_hold) begin
                m_hold = 1'b1; m_hold_addr = exp_addr; m_hold_stale = 1'b0;
            end else if (m_hold && branch_i) begin
                m_hold_stale = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1, 1, 32'h1234, 1, 0, 3); predict();
        total++;
        if ({instr_req_o, fifo_valid_o, fifo_clear_o, busy_o} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got req/valid/clear/busy=%b want 0000",
                            {instr_req_o, fifo_valid_o, fifo_clear_o, busy_o});
        end
        total++;
        if ({instr_addr_o, fifo_addr_o} !== 64'h0) begin
            bad++; $display("FAIL reset_addr got %h/%h want 0/0", instr_addr_o, fifo_addr_o);
        end
        advance();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0); predict();
        total++;
        if ({instr_req_o, busy_o, instr_addr_o} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL post_reset got req=%b busy=%b addr=%h want 0 0 00000000",
                            instr_req_o, busy_o, instr_addr_o);
        end
        advance();
    endtask

    task automatic test_stream();
        drive(1, 1, 32'h100, 1, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o, fifo_clear_o, fifo_addr_o} !== {1'b1, 32'h100, 1'b1, 32'h100}) begin
            bad++; $display("FAIL stream_branch got req=%b addr=%h clr=%b faddr=%h want 1 100 1 100",
                            instr_req_o, instr_addr_o, fifo_clear_o, fifo_addr_o);
        end
        advance();
        for (int k = 1; k <= 3; k++) begin
            drive((k < 3) ? 1 : 0, 0, 0, 1, 1, 0); predict();
            total++;
            if (k < 3 && {instr_req_o, instr_addr_o, fifo_clear_o} !== {1'b1, 32'h100 + 32'(4 * k), 1'b0}) begin
                bad++; $display("FAIL stream_addr%0d got req=%b addr=%h clr=%b want 1 %h 0", k,
                                instr_req_o, instr_addr_o, fifo_clear_o, 32'h100 + 32'(4 * k));
            end
            total++;
            if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, mem(32'h100 + 32'(4 * (k - 1)))}) begin
                bad++; $display("FAIL stream_push%0d got v=%b data=%h want 1 %h", k, fifo_valid_o,
                                fifo_rdata_o, mem(32'h100 + 32'(4 * (k - 1))));
            end
            advance();
        end
    endtask

    task automatic test_unaligned();
        drive(0, 1, 32'h202, 0, 0, 0); predict();
        total++;
        if ({instr_addr_o, fifo_addr_o, fifo_clear_o} !== {32'h200, 32'h202, 1'b1}) begin
            bad++; $display("FAIL unaligned got addr=%h faddr=%h clr=%b want 200 202 1",
                            instr_addr_o, fifo_addr_o, fifo_clear_o);
        end
        advance();
        drive(1, 0, 0, 1, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h200}) begin
            bad++; $display("FAIL unaligned_req got req=%b addr=%h want 1 200", instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 0, 0, 0, 1, 0); predict();
        total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, mem(32'h200)}) begin
            bad++; $display("FAIL unaligned_push got v=%b data=%h want 1 %h", fifo_valid_o, fifo_rdata_o, mem(32'h200));
        end
        advance();
    endtask

    task automatic test_discard();
        drive(1, 0, 0, 1, 0, 0); predict(); advance();
        drive(1, 0, 0, 1, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h208}) begin
            bad++; $display("FAIL discard_second got req=%b addr=%h want 1 208", instr_req_o, instr_addr_o);
        end
        advance();
        drive(1, 1, 32'h400, 0, 0, 0); predict();
        total++;
        if ({instr_req_o, busy_o} !== 2'b01) begin
            bad++; $display("FAIL discard_full got req=%b busy=%b want 0 1", instr_req_o, busy_o);
        end
        advance();
        drive(1, 0, 0, 1, 1, 0); predict();
        total++;
        if ({fifo_valid_o, instr_req_o} !== 2'b00) begin
            bad++; $display("FAIL discard_drop1 got v=%b req=%b want 0 0", fifo_valid_o, instr_req_o);
        end
        advance();
        drive(1, 0, 0, 1, 1, 0); predict();
        total++;
        if ({fifo_valid_o, instr_req_o, instr_addr_o} !== {2'b01, 32'h400}) begin
            bad++; $display("FAIL discard_drop2 got v=%b req=%b addr=%h want 0 1 400",
                            fifo_valid_o, instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 0, 0, 0, 1, 0); predict();
        total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, mem(32'h400)}) begin
            bad++; $display("FAIL discard_push got v=%b data=%h want 1 %h", fifo_valid_o, fifo_rdata_o, mem(32'h400));
        end
        advance();
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 0, 0, 0); predict(); advance();
        drive(0, 0, 0, 0, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h404}) begin
            bad++; $display("FAIL stall_hold got req=%b addr=%h want 1 404", instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 1, 32'h800, 0, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o, fifo_clear_o, fifo_addr_o} !== {1'b1, 32'h404, 1'b1, 32'h800}) begin
            bad++; $display("FAIL stall_branch got req=%b addr=%h clr=%b faddr=%h want 1 404 1 800",
                            instr_req_o, instr_addr_o, fifo_clear_o, fifo_addr_o);
        end
        advance();
        drive(0, 0, 0, 1, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h404}) begin
            bad++; $display("FAIL stall_grant got req=%b addr=%h want 1 404", instr_req_o, instr_addr_o);
        end
        advance();
        drive(1, 0, 0, 1, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h800}) begin
            bad++; $display("FAIL stall_target got req=%b addr=%h want 1 800", instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 0, 0, 0, 1, 0); predict();
        total++;
        if (fifo_valid_o !== 1'b0) begin
            bad++; $display("FAIL stall_stale got v=%b want 0", fifo_valid_o);
        end
        advance();
        drive(0, 0, 0, 0, 1, 0); predict();
        total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, mem(32'h800)}) begin
            bad++; $display("FAIL stall_push got v=%b data=%h want 1 %h", fifo_valid_o, fifo_rdata_o, mem(32'h800));
        end
        advance();
    endtask

    task automatic test_fifo_busy();
        drive(1, 0, 0, 1, 0, 3); predict();
        total++;
        if ({instr_req_o, busy_o} !== 2'b00) begin
            bad++; $display("FAIL fbusy_full got req=%b busy=%b want 0 0", instr_req_o, busy_o);
        end
        advance();
        drive(1, 0, 0, 1, 0, 0); predict(); advance();
        drive(1, 0, 0, 1, 0, 1); predict();
        total++;
        if ({instr_req_o, busy_o} !== 2'b01) begin
            bad++; $display("FAIL fbusy_one got req=%b busy=%b want 0 1", instr_req_o, busy_o);
        end
        advance();
        drive(1, 1, 32'h900, 0, 0, 3); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h900}) begin
            bad++; $display("FAIL fbusy_branch got req=%b addr=%h want 1 900", instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 0, 0, 1, 0, 3); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h900}) begin
            bad++; $display("FAIL fbusy_held got req=%b addr=%h want 1 900", instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 0, 0, 0, 1, 0); predict(); advance();
        drive(0, 0, 0, 0, 1, 0); predict();
        total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, mem(32'h900)}) begin
            bad++; $display("FAIL fbusy_push got v=%b data=%h want 1 %h", fifo_valid_o, fifo_rdata_o, mem(32'h900));
        end
        advance();
    endtask

    task automatic test_wrap();
        drive(1, 1, 32'hFFFF_FFFC, 1, 0, 0); predict();
        total++;
        if (instr_addr_o !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_first got addr=%h want fffffffc", instr_addr_o);
        end
        advance();
        drive(1, 0, 0, 1, 0, 0); predict();
        total++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL wrap_second got req=%b addr=%h want 1 00000000", instr_req_o, instr_addr_o);
        end
        advance();
        drive(0, 0, 0, 0, 1, 0); predict(); advance();
        drive(0, 0, 0, 0, 1, 0); predict();
        total++;
        if ({fifo_valid_o, fifo_rdata_o} !== {1'b1, mem(32'h0)}) begin
            bad++; $display("FAIL wrap_push got v=%b data=%h want 1 %h", fifo_valid_o, fifo_rdata_o, mem(32'h0));
        end
        advance();
    endtask

    task automatic test_random();
        int fb;
        for (int c = 0; c < 4000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            fb = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(0, 3));
            drive(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
                  $urandom, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), fb);
            predict();
            total++;
            if ({instr_req_o, instr_addr_o} !== {exp_req, exp_addr}) begin
                bad++; $display("FAIL rand_req c=%0d got req=%b addr=%h want %b %h", c,
                                instr_req_o, instr_addr_o, exp_req, exp_addr);
            end
            total++;
            if ({fifo_clear_o, fifo_addr_o} !== {exp_clear, exp_faddr}) begin
                bad++; $display("FAIL rand_clear c=%0d got clr=%b faddr=%h want %b %h", c,
                                fifo_clear_o, fifo_addr_o, exp_clear, exp_faddr);
            end
            total++;
            if ({fifo_valid_o, busy_o} !== {exp_valid, exp_busy}) begin
                bad++; $display("FAIL rand_valid c=%0d got v=%b busy=%b want %b %b", c,
                                fifo_valid_o, busy_o, exp_valid, exp_busy);
            end
            if (exp_valid) begin
                total++;
                if ({fifo_rdata_o, fifo_err_o} !== {exp_rdata, drv_err}) begin
                    bad++; $display("FAIL rand_data c=%0d got %h/%b want %h/%b", c,
                                    fifo_rdata_o, fifo_err_o, exp_rdata, drv_err);
                end
            end
            advance();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_unaligned();
        test_discard();
        test_stall();
        test_fifo_busy();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
